// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a
// saturating shift counter. Define USR_ROTATE_EN to make both shifts rotate.

module usrBitCell (
  input  logic       Clk,
  input  logic       notRst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       fromUp,
  input  logic       fromDn,
  input  logic       d,
  output logic       q
);
  always_ff @(posedge Clk or negedge notRst) begin
    if (!notRst) q <= 1'b0;
    else if (en) begin
      case (mode)
        2'b01:   q <= fromUp;
        2'b10:   q <= fromDn;
        2'b11:   q <= d;
        default: q <= q;
      endcase
    end
  end
endmodule

module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       notRst,
  input  logic                       En,
  input  logic [1:0]                 Mode,
  input  logic [WIDTH-1:0]           D,
  input  logic                       SerInR,
  input  logic                       SerInL,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           notQ,
  output logic                       SerOutR,
  output logic                       SerOutL,
  output logic [$clog2(WIDTH+1)-1:0] ShiftCnt,
  output logic                       Drained
);
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic             rIn, lIn;
  logic [WIDTH-1:0] upVec, dnVec;

`ifdef USR_ROTATE_EN
  // Serial inputs are tied off by the wrap-around path in this build.
  logic unusedSerIn;
  assign unusedSerIn = SerInR ^ SerInL;
  assign rIn = Q[0];
  assign lIn = Q[WIDTH-1];
`else
  assign rIn = SerInR;
  assign lIn = SerInL;
`endif

  // Neighbour each bit takes on a right (up) or left (dn) shift.
  assign upVec = {rIn, Q[WIDTH-1:1]};
  assign dnVec = {Q[WIDTH-2:0], lIn};

  for (genvar g = 0; g < WIDTH; g++) begin : gBit
    usrBitCell uCell (
      .Clk    (Clk),
      .notRst (notRst),
      .en     (En),
      .mode   (Mode),
      .fromUp (upVec[g]),
      .fromDn (dnVec[g]),
      .d      (D[g]),
      .q      (Q[g])
    );
  end

  // Reset value is FULL so an empty register reads as drained.
  always_ff @(posedge Clk or negedge notRst) begin
    if (!notRst) ShiftCnt <= FULL;
    else if (En) begin
      case (Mode)
        2'b11:        ShiftCnt <= '0;
        2'b01, 2'b10: if (ShiftCnt != FULL) ShiftCnt <= ShiftCnt + 1'b1;
        default:      ShiftCnt <= ShiftCnt;
      endcase
    end
  end

  assign notQ    = ~Q;
  assign SerOutR = Q[0];
  assign SerOutL = Q[WIDTH-1];
  assign Drained = (ShiftCnt == FULL);
endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8): stimulus queues hand-computed
// expectations tagged with the clock they become valid on; a monitor pops and checks.

module tb_universal_shift_reg;
  logic       Clk = 1'b0;
  logic       notRst;
  logic       En;
  logic [1:0] Mode;
  logic [7:0] D;
  logic       SerInR, SerInL;
  logic [7:0] Q, notQ;
  logic       SerOutR, SerOutL;
  logic [3:0] ShiftCnt;
  logic       Drained;

  universal_shift_reg #(.WIDTH(8)) dut (
    .Clk(Clk), .notRst(notRst), .En(En), .Mode(Mode), .D(D),
    .SerInR(SerInR), .SerInL(SerInL), .Q(Q), .notQ(notQ),
    .SerOutR(SerOutR), .SerOutL(SerOutL), .ShiftCnt(ShiftCnt), .Drained(Drained)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [3:0] cnt;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   posCnt = 0;
  int   vecs = 0;
  int   errs = 0;

  always @(posedge Clk) posCnt <= posCnt + 1;

  // Monitor: every falling edge, check all expectations due by now.
  always begin
    exp_t e;
    logic wantDrn;
    @(negedge Clk);
    while (sb.size() > 0 && sb[0].due <= posCnt) begin
      e = sb.pop_front();
      wantDrn = (e.cnt == 4'd8);
      vecs++;
      if (Q !== e.q || notQ !== ~e.q || SerOutR !== e.q[0] || SerOutL !== e.q[7] ||
          ShiftCnt !== e.cnt || Drained !== wantDrn) begin
        errs++;
        $display("FAIL %s: got Q=%h notQ=%h sor=%b sol=%b cnt=%0d drn=%b, want Q=%h notQ=%h sor=%b sol=%b cnt=%0d drn=%b",
                 e.name, Q, notQ, SerOutR, SerOutL, ShiftCnt, Drained,
                 e.q, ~e.q, e.q[0], e.q[7], e.cnt, wantDrn);
      end
    end
  end

  task automatic expectAt(input string nm, input logic [7:0] eq, input logic [3:0] ec, input int due);
    exp_t e;
    e.name = nm; e.q = eq; e.cnt = ec; e.due = due;
    sb.push_back(e);
  endtask

  // Drive one operation just after a falling edge; it takes effect on the next rising edge.
  task automatic apply(input string nm, input logic en, input logic [1:0] md, input logic [7:0] d,
                       input logic sr, input logic sl, input logic [7:0] eq, input logic [3:0] ec);
    @(negedge Clk); #1;
    En = en; Mode = md; D = d; SerInR = sr; SerInL = sl;
    expectAt(nm, eq, ec, posCnt + 1);
  endtask

  logic [7:0] drainQ [9];
  logic [7:0] l1Q, l2Q, r1Q;

  initial begin
`ifdef USR_ROTATE_EN
    drainQ = '{8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B, 8'hA5, 8'hD2};
    l1Q = 8'h03; l2Q = 8'h06; r1Q = 8'h03;
`else
    drainQ = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    l1Q = 8'h02; l2Q = 8'h05; r1Q = 8'h02;
`endif
    // Reset held through a clock edge with a load presented: no effect.
    notRst = 1'b0; En = 1'b1; Mode = 2'b11; D = 8'hFF; SerInR = 1'b0; SerInL = 1'b0;
    expectAt("reset_state", 8'h00, 4'd8, 1);
    @(negedge Clk); #1;
    notRst = 1'b1; En = 1'b0;

    apply("load_A5", 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hA5, 4'd0);
    for (int i = 0; i < 9; i++)
      apply($sformatf("drain_%0d", i + 1), 1'b1, 2'b01, 8'h00, 1'b1, 1'b0,
            drainQ[i], (i < 8) ? 4'(i + 1) : 4'd8);

    // Load out of the drained state, then mixed-direction shifts on one counter.
    apply("load_81",  1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 8'h81, 4'd0);
    apply("left_0",   1'b1, 2'b10, 8'h00, 1'b0, 1'b0, l1Q,   4'd1);
    apply("left_1",   1'b1, 2'b10, 8'h00, 1'b0, 1'b1, l2Q,   4'd2);
    apply("right_0",  1'b1, 2'b01, 8'h00, 1'b0, 1'b0, r1Q,   4'd3);
    apply("hold",     1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, r1Q,   4'd3);

    apply("load_A5b", 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hA5, 4'd0);
    for (int i = 0; i < 3; i++)
      apply($sformatf("gate_load_%0d", i), 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0, 8'hA5, 4'd0);
    apply("gate_shift", 1'b0, 2'b01, 8'h3C, 1'b1, 1'b1, 8'hA5, 4'd0);

    // Asynchronous reset pulled low between edges, checked before the next rising edge.
    @(negedge Clk);
    @(posedge Clk); #2;
    notRst = 1'b0; En = 1'b1; Mode = 2'b11; D = 8'hFF;
    expectAt("async_reset", 8'h00, 4'd8, posCnt);
    @(negedge Clk); #1;
    expectAt("reset_clk_ignored", 8'h00, 4'd8, posCnt + 1);
    @(negedge Clk); #1;
    notRst = 1'b1; En = 1'b1; Mode = 2'b11; D = 8'h3C;
    expectAt("load_after_reset", 8'h3C, 4'd0, posCnt + 1);
    apply("right_after_reset", 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'h9E, 4'd1);

    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(negedge Clk); #1;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain_timeout: %0d expectations left unchecked, want 0", sb.size());
      errs += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
